sram_dual_req_arbiter: RTL and testbench

- Shares one 1RW1R SRAM macro (port 0 read/write, port 1 read-only; DATA_WIDTH 8, ADDR_WIDTH 5) between two requesters.
- Each requester uses a valid/ready request channel and a read-response channel.
- Port 0 is the contended resource. When possible, the losing requester's read goes to port 1, so two reads complete in one cycle.
- Sits between client logic and the SRAM macro instance, and drives all of the macro's control, address and data inputs.

---
 rtl/sram_dual_req_arbiter.sv | 165 ++++++++++++++++
 tb/tb_sram_dual_req_arbiter.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_dual_req_arbiter.sv
// Two-requester front end for a 1RW1R SRAM macro. Port 0 (read/write) is
// arbitrated with a one-bit fairness pointer; a losing read is steered to the
// read-only port 1 whenever that cannot observe a same-cycle write.
module sram_dual_req_arbiter #(
  parameter int DATA_WIDTH   = 8,
  parameter int ADDR_WIDTH   = 5,
  parameter int READ_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  // requester 0
  input  logic                  req0_valid,
  output logic                  req0_ready,
  input  logic                  req0_we,
  input  logic [ADDR_WIDTH-1:0] req0_addr,
  input  logic [DATA_WIDTH-1:0] req0_wdata,
  output logic                  rsp0_valid,
  output logic [DATA_WIDTH-1:0] rsp0_rdata,
  // requester 1
  input  logic                  req1_valid,
  output logic                  req1_ready,
  input  logic                  req1_we,
  input  logic [ADDR_WIDTH-1:0] req1_addr,
  input  logic [DATA_WIDTH-1:0] req1_wdata,
  output logic                  rsp1_valid,
  output logic [DATA_WIDTH-1:0] rsp1_rdata,
  // SRAM macro port 0 (read/write)
  output logic                  sram_csb0,
  output logic                  sram_web0,
  output logic [ADDR_WIDTH-1:0] sram_addr0,
  output logic [DATA_WIDTH-1:0] sram_din0,
  input  logic [DATA_WIDTH-1:0] sram_dout0,
  // SRAM macro port 1 (read only)
  output logic                  sram_csb1,
  output logic [ADDR_WIDTH-1:0] sram_addr1,
  input  logic [DATA_WIDTH-1:0] sram_dout1
);

  // Preferred requester when both are valid.
  logic r_prio;
  logic w_prio_next;

  // Grant decision: requester N on port P.
  logic w_gnt0_p0, w_gnt1_p0, w_gnt0_p1, w_gnt1_p1;
  logic w_both;
  logic w_same_addr;

  // Per-requester response pipelines: valid bit and port select per stage.
  logic [READ_LATENCY-1:0] r_pipe_v   [2];
  logic [READ_LATENCY-1:0] r_pipe_sel [2];
  logic [1:0]              w_load_v;
  logic [1:0]              w_load_sel;

  // Grant decision from the two requests and the fairness pointer.
  always_comb begin
    w_gnt0_p0   = 1'b0;
    w_gnt1_p0   = 1'b0;
    w_gnt0_p1   = 1'b0;
    w_gnt1_p1   = 1'b0;
    w_both      = req0_valid && req1_valid;
    w_same_addr = (req0_addr == req1_addr);
    if (!rst) begin
      if (req0_valid && !req1_valid) begin
        w_gnt0_p0 = 1'b1;
      end else if (req1_valid && !req0_valid) begin
        w_gnt1_p0 = 1'b1;
      end else if (w_both) begin
        // A losing read rides on port 1 unless the winner writes that word.
        if (!r_prio) begin
          w_gnt0_p0 = 1'b1;
          w_gnt1_p1 = !req1_we && !(req0_we && w_same_addr);
        end else begin
          w_gnt1_p0 = 1'b1;
          w_gnt0_p1 = !req0_we && !(req1_we && w_same_addr);
        end
      end
    end
  end

  assign req0_ready = w_gnt0_p0 || w_gnt0_p1;
  assign req1_ready = w_gnt1_p0 || w_gnt1_p1;

  // A stalled loser becomes the preferred requester for the next cycle.
  always_comb begin
    w_prio_next = r_prio;
    if (!rst && w_both && !(w_gnt0_p1 || w_gnt1_p1)) begin
      w_prio_next = !r_prio;
    end
  end

  // Fairness pointer register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_prio <= 1'b0;
    end else begin
      r_prio <= w_prio_next;
    end
  end

  // SRAM pin drive follows the grant so the macro captures at the handshake edge.
  always_comb begin
    sram_csb0  = !(w_gnt0_p0 || w_gnt1_p0);
    sram_web0  = 1'b1;
    sram_addr0 = '0;
    sram_din0  = '0;
    if (w_gnt0_p0) begin
      sram_web0  = !req0_we;
      sram_addr0 = req0_addr;
      sram_din0  = req0_we ? req0_wdata : '0;
    end else if (w_gnt1_p0) begin
      sram_web0  = !req1_we;
      sram_addr0 = req1_addr;
      sram_din0  = req1_we ? req1_wdata : '0;
    end
    sram_csb1  = !(w_gnt0_p1 || w_gnt1_p1);
    sram_addr1 = '0;
    if (w_gnt0_p1) begin
      sram_addr1 = req0_addr;
    end else if (w_gnt1_p1) begin
      sram_addr1 = req1_addr;
    end
  end

  // Pipeline load values: a granted read and which port serves it.
  always_comb begin
    w_load_v[0]   = (w_gnt0_p0 && !req0_we) || w_gnt0_p1;
    w_load_v[1]   = (w_gnt1_p0 && !req1_we) || w_gnt1_p1;
    w_load_sel[0] = w_gnt0_p1;
    w_load_sel[1] = w_gnt1_p1;
  end

  // Response pipelines shift one stage per cycle; reset drops in-flight reads.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < 2; r++) begin
        r_pipe_v[r]   <= '0;
        r_pipe_sel[r] <= '0;
      end
    end else begin
      for (int r = 0; r < 2; r++) begin
        r_pipe_v[r][0]   <= w_load_v[r];
        r_pipe_sel[r][0] <= w_load_sel[r];
        for (int k = 1; k < READ_LATENCY; k++) begin
          r_pipe_v[r][k]   <= r_pipe_v[r][k-1];
          r_pipe_sel[r][k] <= r_pipe_sel[r][k-1];
        end
      end
    end
  end

  // Response outputs: last pipeline stage picks the port that served the read.
  always_comb begin
    rsp0_valid = r_pipe_v[0][READ_LATENCY-1] && !rst;
    rsp1_valid = r_pipe_v[1][READ_LATENCY-1] && !rst;
    rsp0_rdata = '0;
    rsp1_rdata = '0;
    if (rsp0_valid) begin
      rsp0_rdata = r_pipe_sel[0][READ_LATENCY-1] ? sram_dout1 : sram_dout0;
    end
    if (rsp1_valid) begin
      rsp1_rdata = r_pipe_sel[1][READ_LATENCY-1] ? sram_dout1 : sram_dout0;
    end
  end

endmodule

// File: tb/tb_sram_dual_req_arbiter.sv
// Bench for sram_dual_req_arbiter: a behavioural SRAM macro, a rule-level
// arbitration/memory model, directed scenarios and a randomized phase.
module tb_sram_dual_req_arbiter;

  localparam int DW = 8;
  localparam int AW = 5;
  localparam int L  = 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          req0_valid, req0_ready, req0_we;
  logic [AW-1:0] req0_addr;
  logic [DW-1:0] req0_wdata;
  logic          rsp0_valid;
  logic [DW-1:0] rsp0_rdata;
  logic          req1_valid, req1_ready, req1_we;
  logic [AW-1:0] req1_addr;
  logic [DW-1:0] req1_wdata;
  logic          rsp1_valid;
  logic [DW-1:0] rsp1_rdata;
  logic          sram_csb0, sram_web0, sram_csb1;
  logic [AW-1:0] sram_addr0, sram_addr1;
  logic [DW-1:0] sram_din0, sram_dout0, sram_dout1;

  always #5 clk = ~clk;

  sram_dual_req_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .READ_LATENCY(L)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_we(req0_we),
    .req0_addr(req0_addr), .req0_wdata(req0_wdata),
    .rsp0_valid(rsp0_valid), .rsp0_rdata(rsp0_rdata),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_we(req1_we),
    .req1_addr(req1_addr), .req1_wdata(req1_wdata),
    .rsp1_valid(rsp1_valid), .rsp1_rdata(rsp1_rdata),
    .sram_csb0(sram_csb0), .sram_web0(sram_web0), .sram_addr0(sram_addr0),
    .sram_din0(sram_din0), .sram_dout0(sram_dout0),
    .sram_csb1(sram_csb1), .sram_addr1(sram_addr1), .sram_dout1(sram_dout1)
  );

  // Behavioural 1RW1R macro with L-edge read latency.
  logic [DW-1:0] mem [32];
  logic [DW-1:0] p0 [L];
  logic [DW-1:0] p1 [L];
  always @(posedge clk) begin
    if (!sram_csb0 && !sram_web0) mem[sram_addr0] <= sram_din0;
    if (!sram_csb0 && sram_web0)  p0[0] <= mem[sram_addr0];
    if (!sram_csb1)               p1[0] <= mem[sram_addr1];
    for (int k = 1; k < L; k++) begin
      p0[k] <= p0[k-1];
      p1[k] <= p1[k-1];
    end
  end
  assign sram_dout0 = p0[L-1];
  assign sram_dout1 = p1[L-1];

  // Reference model state.
  typedef struct { int due; logic [DW-1:0] d; } exp_t;
  exp_t          q0[$];
  exp_t          q1[$];
  logic [DW-1:0] shadow [32];
  bit            m_prio;
  int            cyc;
  int            n_total;
  int            n_pass;
  int            dcnt0, dcnt1;

  // Stimulus registers and per-step acceptance seen by the model.
  logic          irst;
  logic          iv   [2];
  logic          iwe  [2];
  logic [AW-1:0] ia   [2];
  logic [DW-1:0] id   [2];
  bit            acc  [2];

  task automatic check(input string tag, input int obs, input int exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s cyc=%0d observed=0x%0h expected=0x%0h", tag, cyc, obs, exp);
  endtask

  // One clock cycle: drive, predict, check at negedge, update model.
  task automatic step();
    bit   eg [2];
    bit   ep1 [2];
    int   own0, w, l, p1own;
    bit   stall, ev0, ev1;
    exp_t e;
    rst = irst;
    req0_valid = iv[0]; req0_we = iwe[0]; req0_addr = ia[0]; req0_wdata = id[0];
    req1_valid = iv[1]; req1_we = iwe[1]; req1_addr = ia[1]; req1_wdata = id[1];
    eg[0] = 0; eg[1] = 0; ep1[0] = 0; ep1[1] = 0;
    own0 = -1; stall = 0; w = 0; l = 0;
    if (!irst) begin
      if (iv[0] != iv[1]) begin
        own0 = iv[0] ? 0 : 1;
        eg[own0] = 1;
      end else if (iv[0] && iv[1]) begin
        w = m_prio ? 1 : 0;
        l = 1 - w;
        own0 = w;
        eg[w] = 1;
        if (!iwe[l] && !(iwe[w] && ia[w] == ia[l])) begin
          eg[l] = 1; ep1[l] = 1;
        end else begin
          stall = 1;
        end
      end
    end
    @(negedge clk);
    check("ready0", req0_ready, eg[0]);
    check("ready1", req1_ready, eg[1]);
    check("csb0", sram_csb0, (own0 < 0) ? 1 : 0);
    check("csb1", sram_csb1, (ep1[0] || ep1[1]) ? 0 : 1);
    if (own0 >= 0) begin
      check("web0", sram_web0, iwe[own0] ? 0 : 1);
      check("addr0", sram_addr0, ia[own0]);
      if (iwe[own0]) check("din0", sram_din0, id[own0]);
    end else begin
      check("web0_idle", sram_web0, 1);
    end
    if (ep1[0] || ep1[1]) begin
      p1own = ep1[0] ? 0 : 1;
      check("addr1", sram_addr1, ia[p1own]);
    end
    dcnt0 += req0_ready ? 1 : 0;
    dcnt1 += req1_ready ? 1 : 0;
    ev0 = !irst && q0.size() > 0 && q0[0].due == cyc;
    ev1 = !irst && q1.size() > 0 && q1[0].due == cyc;
    check("rsp0_valid", rsp0_valid, ev0);
    check("rsp1_valid", rsp1_valid, ev1);
    check("rsp0_rdata", rsp0_rdata, ev0 ? q0[0].d : 0);
    check("rsp1_rdata", rsp1_rdata, ev1 ? q1[0].d : 0);
    if (ev0) void'(q0.pop_front());
    if (ev1) void'(q1.pop_front());
    if (irst) begin
      q0.delete(); q1.delete();
      m_prio = 0;
    end else begin
      // Reads see memory as it was before this edge's write.
      for (int i = 0; i < 2; i++) begin
        if (eg[i] && !iwe[i]) begin
          e.due = cyc + L; e.d = shadow[ia[i]];
          if (i == 0) q0.push_back(e); else q1.push_back(e);
        end
      end
      if (own0 >= 0 && iwe[own0]) shadow[ia[own0]] = id[own0];
      if (stall) m_prio = (l == 1);
    end
    acc[0] = eg[0]; acc[1] = eg[1];
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic idle(input int n);
    iv[0] = 0; iv[1] = 0;
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic do_reset();
    irst = 1; iv[0] = 0; iv[1] = 0;
    step();
    irst = 0;
  endtask

  // Present up to two requests and hold each until the model says accepted.
  task automatic run_req(input bit v0, input bit we0, input int a0, input int d0,
                         input bit v1, input bit we1, input int a1, input int d1);
    int n;
    iv[0] = v0; iwe[0] = we0; ia[0] = AW'(a0); id[0] = DW'(d0);
    iv[1] = v1; iwe[1] = we1; ia[1] = AW'(a1); id[1] = DW'(d1);
    n = 0;
    while ((iv[0] || iv[1]) && n < 8) begin
      step();
      if (acc[0]) iv[0] = 0;
      if (acc[1]) iv[1] = 0;
      n++;
    end
    check("hold_timeout", int'(iv[0] || iv[1]), 0);
    iv[0] = 0; iv[1] = 0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog cyc=%0d observed=timeout expected=finish", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    n_total = 0; n_pass = 0; cyc = 0; m_prio = 0; dcnt0 = 0; dcnt1 = 0;
    irst = 1;
    for (int i = 0; i < 2; i++) begin
      iv[i] = 0; iwe[i] = 0; ia[i] = '0; id[i] = '0; acc[i] = 0;
    end
    for (int i = 0; i < 32; i++) shadow[i] = '0;
    @(posedge clk); #1;

    // Reset state.
    step(); step();
    irst = 0;

    // Fill every word through the arbiter so the model knows all contents.
    for (int a = 0; a < 32; a++) run_req(1, 1, a, a * 7 + 3, 0, 0, 0, 0);

    // Write then read on requester 0.
    run_req(1, 1, 3, 8'h5A, 0, 0, 0, 0);
    run_req(1, 0, 3, 0, 0, 0, 0, 0);
    check("t1_rsp0_valid", rsp0_valid, 1);
    check("t1_rsp0_rdata", rsp0_rdata, 8'h5A);
    check("t1_rsp1_valid", rsp1_valid, 0);
    idle(2);

    // Dual read in one cycle.
    run_req(1, 1, 1, 8'h11, 1, 1, 2, 8'h22);
    run_req(1, 0, 1, 0, 1, 0, 2, 0);
    check("t2_rsp0_rdata", rsp0_rdata, 8'h11);
    check("t2_rsp1_rdata", rsp1_rdata, 8'h22);
    idle(2);

    // Write/write contention from prio 0, then readback.
    do_reset();
    run_req(1, 1, 4, 8'hAA, 1, 1, 5, 8'hBB);
    run_req(1, 0, 4, 0, 1, 0, 5, 0);
    check("t3_rsp0_rdata", rsp0_rdata, 8'hAA);
    check("t3_rsp1_rdata", rsp1_rdata, 8'hBB);
    idle(2);

    // Same-address write/read collision stalls the read.
    do_reset();
    run_req(1, 1, 7, 8'hC3, 1, 0, 7, 0);
    check("t4_rsp1_valid", rsp1_valid, 1);
    check("t4_rsp1_rdata", rsp1_rdata, 8'hC3);
    idle(2);

    // Fairness under continuous writes from both requesters.
    do_reset();
    dcnt0 = 0; dcnt1 = 0;
    for (int i = 0; i < 2; i++) begin
      iv[i] = 1; iwe[i] = 1; ia[i] = AW'($urandom_range(0, 31)); id[i] = DW'($urandom);
    end
    for (int c = 0; c < 10; c++) begin
      step();
      for (int i = 0; i < 2; i++) begin
        if (acc[i]) begin ia[i] = AW'($urandom_range(0, 31)); id[i] = DW'($urandom); end
      end
    end
    check("t5_grants0", dcnt0, 5);
    check("t5_grants1", dcnt1, 5);
    idle(2);

    // Reset right after a granted read: its response must never appear.
    iv[0] = 1; iwe[0] = 0; ia[0] = 5'd3; iv[1] = 0;
    step();
    iv[0] = 0; irst = 1;
    step();
    irst = 0;
    check("t6_csb0", sram_csb0, 1);
    check("t6_csb1", sram_csb1, 1);
    idle(2);
    run_req(1, 0, 3, 0, 1, 1, 9, 8'h77);
    idle(2);

    // Randomized traffic with occasional resets, narrow address range.
    for (int c = 0; c < 400; c++) begin
      irst = ($urandom_range(0, 99) == 0);
      for (int i = 0; i < 2; i++) begin
        if (!iv[i] && $urandom_range(0, 9) < 7) begin
          iv[i] = 1; iwe[i] = $urandom_range(0, 1) == 1;
          ia[i] = AW'($urandom_range(0, 7)); id[i] = DW'($urandom);
        end
      end
      step();
      for (int i = 0; i < 2; i++) if (acc[i]) iv[i] = 0;
    end
    irst = 0;
    idle(L + 2);
    check("drain", q0.size() + q1.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
